// File: rtl/int_rs_pkg.sv
// Shared definitions for the integer-adder reservation station.
// Opcode encodings, the reserved "value present" tag and the entry record
// at the default geometry (4 entries, 4-bit tags, 32-bit data).
package int_rs_pkg;

    localparam int RS_NUM_ENTRIES = 4;
    localparam int RS_TAG_W       = 4;
    localparam int RS_DATA_W      = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Tag value meaning "operand already holds its value".
    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                 busy;
        logic                 op;
        logic [RS_TAG_W-1:0]  dest;
        logic [RS_TAG_W-1:0]  qj;
        logic [RS_DATA_W-1:0] vj;
        logic [RS_TAG_W-1:0]  qk;
        logic [RS_DATA_W-1:0] vk;
    } rs_entry_t;

endpackage

// File: rtl/int_rs_pick.sv
// Fixed-priority picker: lowest set request bit wins.
// Produces a one-hot grant, the binary index of the winner and an any-valid flag.
// Used for both free-entry allocation and ready-entry selection.
module int_rs_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise an
        // all-zero request would leave gnt/idx unassigned and infer latches.
        gnt = '0;
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                // NOTE: blocking assignments here are intentional; later loop
                // iterations must overwrite earlier ones within the same pass.
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_add_rs.sv
// Reservation station in front of the 32-bit integer adder.
// Holds issued ADD/SUB ops until both operands are present, snoops the CDB
// for pending tags and dispatches one ready op per cycle as registered
// (a, b, cin, tag). SUB is sent as a + ~b + 1.
// Optional build macro INT_ADD_RS_STATS_EN adds a saturating 32-bit
// stall_cnt output counting issue attempts made while the station is full.
module int_add_rs
    import int_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_op,
    input  logic [TAG_W-1:0]  issue_dest,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,

    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,

    input  logic              fu_ready,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic              disp_cin,
    output logic [TAG_W-1:0]  disp_tag
`ifdef INT_ADD_RS_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    // Same layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              busy;
        logic              op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
    } entry_t;

    entry_t ent_q [NUM_ENTRIES];
    entry_t ent_d [NUM_ENTRIES];
    entry_t new_ent;
    entry_t sel_ent;

    logic [NUM_ENTRIES-1:0] free_req, free_gnt;
    logic [NUM_ENTRIES-1:0] rdy_req,  rdy_gnt;
    logic [IDX_W-1:0]       free_idx, rdy_idx;
    logic                   free_any, rdy_any;
    logic                   do_issue, do_disp;

    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_a_q,     disp_a_d;
    logic [DATA_W-1:0] disp_b_q,     disp_b_d;
    logic              disp_cin_q,   disp_cin_d;
    logic [TAG_W-1:0]  disp_tag_q,   disp_tag_d;

    // Free and ready request vectors, both from registered entry state only.
    always_comb begin
        free_req = '0;
        rdy_req  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_req[i] = ~ent_q[i].busy;
            rdy_req[i]  = ent_q[i].busy && (ent_q[i].qj == NO_TAG) && (ent_q[i].qk == NO_TAG);
        end
    end

    int_rs_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_pick (
        .req (free_req),
        .gnt (free_gnt),
        .idx (free_idx),
        .any (free_any)
    );

    int_rs_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_rdy_pick (
        .req (rdy_req),
        .gnt (rdy_gnt),
        .idx (rdy_idx),
        .any (rdy_any)
    );

    // Allocation writes through the one-hot grant; the index is not needed.
    logic unused_free_idx;
    assign unused_free_idx = ^free_idx;

    // A slot freed by this cycle's dispatch only shows up next cycle.
    assign issue_ready = free_any;
    assign do_issue    = issue_valid & issue_ready;
    assign do_disp     = fu_ready & rdy_any;

    // Build the incoming entry, forwarding a same-cycle CDB broadcast.
    always_comb begin
        new_ent.busy = 1'b1;
        new_ent.op   = issue_op;
        new_ent.dest = issue_dest;
        new_ent.qj   = issue_qj;
        new_ent.vj   = issue_vj;
        new_ent.qk   = issue_qk;
        new_ent.vk   = issue_vk;
        if (cdb_valid && (issue_qj != NO_TAG) && (issue_qj == cdb_tag)) begin
            new_ent.qj = NO_TAG;
            new_ent.vj = cdb_data;
        end
        if (cdb_valid && (issue_qk != NO_TAG) && (issue_qk == cdb_tag)) begin
            new_ent.qk = NO_TAG;
            new_ent.vk = cdb_data;
        end
    end

    // Entry next state: CDB capture, dispatch free and issue write.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && cdb_valid) begin
                if ((ent_q[i].qj != NO_TAG) && (ent_q[i].qj == cdb_tag)) begin
                    ent_d[i].qj = NO_TAG;
                    ent_d[i].vj = cdb_data;
                end
                if ((ent_q[i].qk != NO_TAG) && (ent_q[i].qk == cdb_tag)) begin
                    ent_d[i].qk = NO_TAG;
                    ent_d[i].vk = cdb_data;
                end
            end
            if (do_disp && rdy_gnt[i]) begin
                ent_d[i].busy = 1'b0;
            end
            // The free grant never hits a busy (hence dispatching) entry.
            if (do_issue && free_gnt[i]) begin
                ent_d[i] = new_ent;
            end
        end
    end

    // Dispatch register next state; data holds when nothing is sent.
    always_comb begin
        sel_ent      = ent_q[rdy_idx];
        disp_valid_d = do_disp;
        disp_a_d     = disp_a_q;
        disp_b_d     = disp_b_q;
        disp_cin_d   = disp_cin_q;
        disp_tag_d   = disp_tag_q;
        if (do_disp) begin
            disp_a_d   = sel_ent.vj;
            disp_tag_d = sel_ent.dest;
            if (sel_ent.op == OP_SUB) begin
                disp_b_d   = ~sel_ent.vk;
                disp_cin_d = 1'b1;
            end else begin
                disp_b_d   = sel_ent.vk;
                disp_cin_d = 1'b0;
            end
        end
    end

    // Entry storage: only the busy bits are reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rst) begin
                // NOTE: operand payload is left unreset; a clear busy bit
                // makes it dead, so resetting it would only cost reset fanout.
                ent_q[i].busy <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all
                // flops update from the same pre-edge values.
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Dispatch output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid_q <= 1'b0;
            disp_a_q     <= '0;
            disp_b_q     <= '0;
            disp_cin_q   <= 1'b0;
            disp_tag_q   <= '0;
        end else begin
            disp_valid_q <= disp_valid_d;
            disp_a_q     <= disp_a_d;
            disp_b_q     <= disp_b_d;
            disp_cin_q   <= disp_cin_d;
            disp_tag_q   <= disp_tag_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_a     = disp_a_q;
    assign disp_b     = disp_b_q;
    assign disp_cin   = disp_cin_q;
    assign disp_tag   = disp_tag_q;

`ifdef INT_ADD_RS_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count rejected issue attempts, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && !issue_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_int_add_rs.sv
// Bench for int_add_rs: directed issue/CDB stimulus pushes expected dispatches
// (operands, carry-in, tag and dispatch cycle) into a queue; a monitor on the
// falling edge pops and compares each dispatch the DUT presents.
module tb_int_add_rs;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_op;
    logic [3:0]  issue_dest;
    logic [3:0]  issue_qj;
    logic [31:0] issue_vj;
    logic [3:0]  issue_qk;
    logic [31:0] issue_vk;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_ready;
    logic        disp_valid;
    logic [31:0] disp_a;
    logic [31:0] disp_b;
    logic        disp_cin;
    logic [3:0]  disp_tag;
`ifdef INT_ADD_RS_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int_add_rs #(.NUM_ENTRIES(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_dest  (issue_dest),
        .issue_qj    (issue_qj),
        .issue_vj    (issue_vj),
        .issue_qk    (issue_qk),
        .issue_vk    (issue_vk),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_ready    (fu_ready),
        .disp_valid  (disp_valid),
        .disp_a      (disp_a),
        .disp_b      (disp_b),
        .disp_cin    (disp_cin),
        .disp_tag    (disp_tag)
`ifdef INT_ADD_RS_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge count; a dispatch registered at edge N is seen with cyc==N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic op, input logic [3:0] dest,
                               input logic [3:0] qj, input logic [31:0] vj,
                               input logic [3:0] qk, input logic [31:0] vk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_dest  = dest;
        issue_qj    = qj;
        issue_vj    = vj;
        issue_qk    = qk;
        issue_vk    = vk;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [3:0] tag, input int at_cyc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.cin = cin;
        e.tag = tag;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    // Monitor: every dispatch must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (disp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dispatch: got tag %0d a=0x%0h, expected no dispatch (cyc=%0d)",
                         disp_tag, disp_a, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("disp_tag",   64'(disp_tag), 64'(e.tag));
                check("disp_a",     64'(disp_a),   64'(e.a));
                check("disp_b",     64'(disp_b),   64'(e.b));
                check("disp_cin",   64'(disp_cin), 64'(e.cin));
                check("disp_cycle", 64'(cyc),      64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_op    = 1'b0;
        issue_dest  = '0;
        issue_qj    = '0;
        issue_vj    = '0;
        issue_qk    = '0;
        issue_vk    = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;
        fu_ready    = 1'b0;

        // Reset then idle.
        repeat (2) tick();
        rst = 1'b0;
        check("rst_disp_valid",  64'(disp_valid),  64'd0);
        check("rst_disp_a",      64'(disp_a),      64'd0);
        check("rst_disp_b",      64'(disp_b),      64'd0);
        check("rst_disp_cin",    64'(disp_cin),    64'd0);
        check("rst_disp_tag",    64'(disp_tag),    64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
`ifdef INT_ADD_RS_STATS_EN
        check("rst_stall_cnt",   64'(stall_cnt),   64'd0);
`endif
        tick();
        check("idle_disp_valid", 64'(disp_valid), 64'd0);

        // Ready ADD: dispatch one cycle after the issue edge.
        fu_ready = 1'b1;
        drive_issue(1'b0, 4'd3, 4'd0, 32'hd2d6fc38, 4'd0, 32'hb7a9a5b8);
        push(32'hd2d6fc38, 32'hb7a9a5b8, 1'b0, 4'd3, cyc + 2);
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();

        // SUB: b is inverted, carry-in set.
        drive_issue(1'b1, 4'd6, 4'd0, 32'h00000005, 4'd0, 32'h00000003);
        push(32'h00000005, 32'hfffffffc, 1'b1, 4'd6, cyc + 2);
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();

        // CDB wakeup on j, broadcast two cycles after issue.
        drive_issue(1'b0, 4'd7, 4'd5, 32'h0, 4'd0, 32'h11111111);
        push(32'h12345678, 32'h11111111, 1'b0, 4'd7, cyc + 4);
        tick();
        issue_valid = 1'b0;
        tick();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'h12345678;
        tick();
        cdb_valid = 1'b0;
        repeat (3) tick();

        // Same op with the broadcast in the issue cycle itself.
        drive_issue(1'b0, 4'd7, 4'd5, 32'h0, 4'd0, 32'h11111111);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'h12345678;
        push(32'h12345678, 32'h11111111, 1'b0, 4'd7, cyc + 2);
        tick();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        repeat (3) tick();

        // CDB wakeup on k for a SUB: b = ~4.
        drive_issue(1'b1, 4'd10, 4'd0, 32'h0000000a, 4'd9, 32'h0);
        push(32'h0000000a, 32'hfffffffb, 1'b1, 4'd10, cyc + 3);
        tick();
        issue_valid = 1'b0;
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd9;
        cdb_data    = 32'h00000004;
        tick();
        cdb_valid = 1'b0;
        repeat (3) tick();

        // Fill all four entries under backpressure.
        fu_ready = 1'b0;
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            drive_issue(1'b0, 4'(i), 4'd0, 32'h100 + 32'(i), 4'd0, 32'(i));
            push(32'h100 + 32'(i), 32'(i), 1'b0, 4'(i), c0 + 5 + i);
            tick();
        end
        check("full_issue_ready", 64'(issue_ready), 64'd0);
        // Fifth issue while full must be dropped.
        drive_issue(1'b0, 4'd5, 4'd0, 32'h555, 4'd0, 32'h5);
        tick();
        issue_valid = 1'b0;
        check("full_issue_ready_hold", 64'(issue_ready), 64'd0);
`ifdef INT_ADD_RS_STATS_EN
        check("stall_cnt_one", 64'(stall_cnt), 64'd1);
`endif
        fu_ready = 1'b1;
        tick();
        check("freed_issue_ready", 64'(issue_ready), 64'd1);
        repeat (5) tick();

        // Reset mid-operation discards all entries.
        fu_ready = 1'b0;
        drive_issue(1'b0, 4'd1, 4'd0, 32'haaaa, 4'd0, 32'h1);
        tick();
        drive_issue(1'b0, 4'd2, 4'd0, 32'hbbbb, 4'd0, 32'h2);
        tick();
        drive_issue(1'b0, 4'd3, 4'd7, 32'h0, 4'd0, 32'h3);
        tick();
        issue_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_issue_ready", 64'(issue_ready), 64'd1);
        check("midrst_disp_valid",  64'(disp_valid),  64'd0);
`ifdef INT_ADD_RS_STATS_EN
        check("midrst_stall_cnt",   64'(stall_cnt),   64'd0);
`endif
        fu_ready  = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = 4'd7;
        cdb_data  = 32'hdeadbeef;
        tick();
        cdb_valid = 1'b0;
        repeat (4) tick();
        check("post_rst_issue_ready", 64'(issue_ready), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_add_rs.md
Name: int_add_rs

Overview:
- Reservation station that feeds the 32-bit integer adder functional unit (the rdcla adder) in the Tomasulo core.
- Accepts issued add/sub instructions and holds them until both operands are available.
- Snoops the common data bus (CDB) for pending source tags.
- Dispatches ready instructions to the adder as registered (a, b, cin, tag) operands. Subtract is issued as a + ~b + 1.

Parameters:
- NUM_ENTRIES, 4, number of reservation station entries (2..16).
- TAG_W, 4, width of the ROB/RS tag. Tag 0 is reserved and means "operand value present".
- DATA_W, 32, operand width. It must match the adder width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one entry is free.
- issue_op  in  1  0 = ADD, 1 = SUB.
- issue_dest  in  TAG_W  tag of the result this instruction produces.
- issue_qj  in  TAG_W  source j producer tag; 0 = vj valid.
- issue_vj  in  DATA_W  source j value.
- issue_qk  in  TAG_W  source k producer tag; 0 = vk valid.
- issue_vk  in  DATA_W  source k value.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcasting tag.
- cdb_data  in  DATA_W  broadcast value.
- fu_ready  in  1  the adder can accept an operation this cycle.
- disp_valid  out  1  dispatch valid, one-cycle pulse per op.
- disp_a  out  DATA_W  adder operand a.
- disp_b  out  DATA_W  adder operand b.
- disp_cin  out  1  adder carry-in.
- disp_tag  out  TAG_W  dest tag travelling with the op.

Behaviour:
- Per-entry state: busy, op, dest, qj, vj, qk, vk.
- Reset (synchronous, while rst=1):
  - All busy bits clear; the other entry fields are don't-care.
  - disp_valid=0; disp_a=0, disp_b=0, disp_cin=0, disp_tag=0.
  - issue_ready=1 in the first cycle after reset.
  - Reset mid-operation discards every entry and any pending dispatch, with no partial output.
- issue_ready:
  - Combinational from registered busy bits: OR of ~busy.
  - It does not depend on same-cycle dispatch freeing. A freed entry is usable on the next cycle.
- Issue:
  - Occurs on issue_valid & issue_ready.
  - Writes the lowest-index free entry.
  - Same-cycle CDB forwarding: if cdb_valid and cdb_tag==issue_qj with issue_qj!=0, store vj=cdb_data and qj=0. The same rule applies to k.
  - issue_valid while full is ignored; no state change.
- CDB snoop:
  - Each busy entry with qj==cdb_tag (qj!=0) captures vj=cdb_data and qj=0 at the clock edge. The same rule applies to k.
- Ready and dispatch:
  - An entry is ready when busy & qj==0 & qk==0, evaluated from registered state.
  - An operand captured from the CDB therefore makes the entry ready one cycle after the broadcast. This gives minimum issue-to-dispatch latency of 1 cycle for an instruction whose operands are already valid.
  - If fu_ready=1 and any entry is ready, the lowest-index ready entry is selected. At the clock edge:
    - its busy bit clears;
    - disp_valid<=1, disp_a<=vj, disp_tag<=dest;
    - ADD: disp_b<=vk, disp_cin<=0;
    - SUB: disp_b<=~vk, disp_cin<=1.
  - Otherwise disp_valid<=0 and the disp_* data registers hold their previous values.
  - fu_ready=0 blocks selection; entries stay put. At most one dispatch per cycle.
- Simultaneous events:
  - Issue, CDB capture and dispatch of different entries can all happen in the same cycle.
  - A CDB match on an entry being dispatched is harmless, because it is already ready and has no pending tag.
  - Issue can never target the dispatching entry, because freeing takes effect next cycle.
- Width: all arithmetic is left to the adder. Inversion is bitwise over DATA_W, with no sign extension.

Optional Feature:
- Macro INT_ADD_RS_STATS_EN.
- Defined:
  - Adds output stall_cnt (out, 32 bits), cleared by rst.
  - Increments once per cycle with issue_valid & ~issue_ready.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package int_rs_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - TAG_NONE='0;
  - packed struct rs_entry_t {busy, op, dest, qj, vj, qk, vk}, parameterised via package localparams matching the defaults.
- Sub-module int_rs_pick:
  - NUM_ENTRIES-bit request vector in; one-hot grant plus index plus any-valid out; lowest index wins.
  - Instantiated twice: free-entry allocation and ready-entry selection.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: disp_valid=0, disp_a=0, disp_tag=0, issue_ready=1.
- Ready ADD:
  - Stimulus: issue op=ADD, dest=3, qj=qk=0, vj=32'hd2d6fc38, vk=32'hb7a9a5b8, fu_ready=1.
  - Required, next cycle: disp_valid=1, disp_a=32'hd2d6fc38, disp_b=32'hb7a9a5b8, disp_cin=0, disp_tag=3.
- SUB inversion:
  - Stimulus: issue op=SUB, vj=32'h00000005, vk=32'h00000003.
  - Required: disp_b=32'hfffffffc, disp_cin=1.
- CDB wakeup and same-cycle forwarding:
  - Stimulus: issue qj=5 with vk ready; cdb_valid, cdb_tag=5, cdb_data=32'h12345678 two cycles later.
  - Required: dispatch one cycle after the broadcast with disp_a=32'h12345678.
  - Repeat with the broadcast in the issue cycle; required: identical result.
- Full and backpressure:
  - Stimulus: hold fu_ready=0 and issue 4 ready ops (dest 1..4).
  - Required: issue_ready=0 after the 4th; a 5th issue is ignored.
  - Stimulus: raise fu_ready.
  - Required: dispatch in index order, disp_tag 1,2,3,4 on consecutive cycles; issue_ready=1 in the cycle after the first dispatch.
- Reset mid-operation:
  - Stimulus: with 3 entries busy and one waiting on tag 7, assert rst for 1 cycle, then broadcast tag 7.
  - Required: no dispatch, issue_ready=1.
  - With INT_ADD_RS_STATS_EN defined: stall_cnt=0.
